// File: rtl/l2_prefetch_accuracy_rolling_sampler.sv
// Rolling-window sampler for L2 prefetch accuracy: folds per-cycle issued/useful increments into
// windows of GRANULARITY issued events and strobes one sample per closed or flushed window.
module l2_prefetch_accuracy_rolling_sampler #(
    parameter int unsigned GRANULARITY = 1000,
    parameter int unsigned INC_W       = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [INC_W-1:0] x_inc,
    input  logic [INC_W-1:0] y_inc,
    input  logic             flush,
    output logic             en,
    output logic [63:0]      data_yAxisPt,
    output logic [63:0]      data_xAxisPt,
    output logic [63:0]      stamp
);

    localparam int unsigned WinW = $clog2(GRANULARITY + 1);
    // One spare bit so the window plus an increment (or a carry plus one) never overflows.
    localparam int unsigned SumW = WinW + 1;

    typedef enum logic [0:0] {
        StAcc,
        StFlushPend
    } state_e;

    state_e            state_q;
    logic [63:0]       stamp_cnt_q;
    logic [63:0]       total_x_q;
    logic [WinW-1:0]   win_x_q;
    logic [63:0]       win_y_q;

    logic [INC_W-1:0]  ex;
    logic [INC_W-1:0]  ey;
    logic [SumW-1:0]   sum_x;
    logic [64:0]       sum_y_wide;
    logic [63:0]       sum_y;
    logic [63:0]       total_x_next;
    logic [SumW-1:0]   carry;
    logic              win_close;
    logic              win_nonempty;

    always_comb begin
        ex           = enable ? x_inc : '0;
        ey           = enable ? y_inc : '0;
        sum_x        = SumW'(win_x_q) + SumW'(ex);
        sum_y_wide   = {1'b0, win_y_q} + 65'(ey);
        sum_y        = sum_y_wide[64] ? '1 : sum_y_wide[63:0];
        total_x_next = total_x_q + 64'(ex);
        win_close    = sum_x >= SumW'(GRANULARITY);
        carry        = sum_x - SumW'(GRANULARITY);
        win_nonempty = (sum_x != '0) || (sum_y != '0);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= StAcc;
            stamp_cnt_q  <= '0;
            total_x_q    <= '0;
            win_x_q      <= '0;
            win_y_q      <= '0;
            en           <= 1'b0;
            data_yAxisPt <= '0;
            data_xAxisPt <= '0;
            stamp        <= '0;
        end else begin
            stamp_cnt_q <= stamp_cnt_q + 64'd1;
            total_x_q   <= total_x_next;
            en          <= 1'b0;
            unique case (state_q)
                StAcc: begin
                    if (win_close) begin
                        en           <= 1'b1;
                        data_yAxisPt <= sum_y;
                        data_xAxisPt <= total_x_next;
                        stamp        <= stamp_cnt_q;
                        win_x_q      <= carry[WinW-1:0];
                        win_y_q      <= '0;
                        // A flush landing on a close with leftover carry needs a second sample.
                        if (flush && (carry != '0)) begin
                            state_q <= StFlushPend;
                        end
                    end else if (flush && win_nonempty) begin
                        en           <= 1'b1;
                        data_yAxisPt <= sum_y;
                        data_xAxisPt <= total_x_next;
                        stamp        <= stamp_cnt_q;
                        win_x_q      <= '0;
                        win_y_q      <= '0;
                    end else begin
                        win_x_q <= sum_x[WinW-1:0];
                        win_y_q <= sum_y;
                    end
                end
                StFlushPend: begin
                    // Carry plus this cycle's increments goes out as a forced partial window.
                    if (win_nonempty) begin
                        en           <= 1'b1;
                        data_yAxisPt <= sum_y;
                        data_xAxisPt <= total_x_next;
                        stamp        <= stamp_cnt_q;
                    end
                    win_x_q <= '0;
                    win_y_q <= '0;
                    state_q <= StAcc;
                end
                default: state_q <= StAcc;
            endcase
        end
    end

endmodule

// File: tb/tb_l2_prefetch_accuracy_rolling_sampler.sv
// Bench for l2_prefetch_accuracy_rolling_sampler: directed scenarios plus random traffic, each
// cycle compared with a window-accounting model of the sampler.
module tb_l2_prefetch_accuracy_rolling_sampler;

    localparam int unsigned G  = 4;
    localparam int unsigned IW = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic [IW-1:0] x_inc = '0;
    logic [IW-1:0] y_inc = '0;
    logic          flush = 1'b0;
    logic          en;
    logic [63:0]   data_yAxisPt;
    logic [63:0]   data_xAxisPt;
    logic [63:0]   stamp;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: window contents, running issued total, cycle count, pending forced flush.
    longint unsigned m_stamp;
    longint unsigned m_total;
    int              m_winx;
    logic [63:0]     m_winy;
    bit              m_pend;
    logic            exp_en;
    logic [63:0]     exp_y;
    logic [63:0]     exp_x;
    logic [63:0]     exp_stamp;

    l2_prefetch_accuracy_rolling_sampler #(
        .GRANULARITY (G),
        .INC_W       (IW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .x_inc        (x_inc),
        .y_inc        (y_inc),
        .flush        (flush),
        .en           (en),
        .data_yAxisPt (data_yAxisPt),
        .data_xAxisPt (data_xAxisPt),
        .stamp        (stamp)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] sat_add(input logic [63:0] a, input int b);
        logic [64:0] s;
        s = {1'b0, a} + 65'(b);
        return s[64] ? 64'hFFFF_FFFF_FFFF_FFFF : s[63:0];
    endfunction

    task automatic model_reset();
        m_stamp = 0; m_total = 0; m_winx = 0; m_winy = '0; m_pend = 0;
        exp_en = 0; exp_y = '0; exp_x = '0; exp_stamp = '0;
    endtask

    task automatic model_step(input bit e, input int x, input int y, input bit fl);
        int          ex, ey, sx;
        logic [63:0] sy;
        bit          emit;
        ex   = e ? x : 0;
        ey   = e ? y : 0;
        sx   = m_winx + ex;
        sy   = sat_add(m_winy, ey);
        emit = 0;
        if (m_pend) begin
            emit = (sx != 0) || (sy != 0);
            m_winx = 0; m_winy = '0; m_pend = 0;
        end else if (sx >= int'(G)) begin
            emit = 1;
            m_winx = sx - int'(G); m_winy = '0;
            m_pend = fl && (m_winx != 0);
        end else if (fl) begin
            emit = (sx != 0) || (sy != 0);
            m_winx = 0; m_winy = '0;
        end else begin
            m_winx = sx; m_winy = sy;
        end
        exp_en = emit;
        if (emit) begin
            exp_y     = sy;
            exp_x     = m_total + longint'(ex);
            exp_stamp = m_stamp;
        end
        m_total = m_total + longint'(ex);
        m_stamp = m_stamp + 1;
    endtask

    task automatic drive(input bit e, input int x, input int y, input bit fl);
        enable = e;
        x_inc  = IW'(x);
        y_inc  = IW'(y);
        flush  = fl;
        @(posedge clock);
        model_step(e, x, y, fl);
        #1;
    endtask

    task automatic do_reset();
        enable = 0; x_inc = '0; y_inc = '0; flush = 0;
        reset = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1;
        model_reset();
    endtask

    task automatic test_reset();
        enable = 1; x_inc = 2'd3; y_inc = 2'd3; flush = 1;
        reset = 0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if ({en, data_yAxisPt, data_xAxisPt, stamp} !== {1'b0, 64'd0, 64'd0, 64'd0}) begin
            n_fail++;
            $display("FAIL reset_values: got en=%b y=%0d x=%0d stamp=%0d, want all zero",
                     en, data_yAxisPt, data_xAxisPt, stamp);
        end
        @(negedge clock);
        reset = 1;
        for (int c = 0; c < 3; c++) begin
            drive(1, 0, 0, 0);
            n_checks++;
            if ({en, data_yAxisPt, data_xAxisPt, stamp} !== {exp_en, exp_y, exp_x, exp_stamp}) begin
                n_fail++;
                $display("FAIL reset_idle c%0d: got en=%b y=%0d x=%0d st=%0d, want en=%b y=%0d x=%0d st=%0d",
                         c, en, data_yAxisPt, data_xAxisPt, stamp, exp_en, exp_y, exp_x, exp_stamp);
            end
        end
    endtask

    task automatic test_basic_window();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            drive(1, (c < 4) ? 1 : 0, (c == 0 || c == 2) ? 1 : 0, 0);
            n_checks++;
            if ({en, data_yAxisPt, data_xAxisPt, stamp} !== {exp_en, exp_y, exp_x, exp_stamp}) begin
                n_fail++;
                $display("FAIL basic c%0d: got en=%b y=%0d x=%0d st=%0d, want en=%b y=%0d x=%0d st=%0d",
                         c, en, data_yAxisPt, data_xAxisPt, stamp, exp_en, exp_y, exp_x, exp_stamp);
            end
            if (c == 3) begin
                n_checks++;
                if ({en, data_yAxisPt, data_xAxisPt, stamp} !== {1'b1, 64'd2, 64'd4, 64'd3}) begin
                    n_fail++;
                    $display("FAIL basic_close: got en=%b y=%0d x=%0d st=%0d, want en=1 y=2 x=4 st=3",
                             en, data_yAxisPt, data_xAxisPt, stamp);
                end
            end
        end
    endtask

    task automatic test_overshoot();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            drive(1, (c < 3) ? 3 : 0, 0, 0);
            n_checks++;
            if ({en, data_yAxisPt, data_xAxisPt, stamp} !== {exp_en, exp_y, exp_x, exp_stamp}) begin
                n_fail++;
                $display("FAIL overshoot c%0d: got en=%b y=%0d x=%0d st=%0d, want en=%b y=%0d x=%0d st=%0d",
                         c, en, data_yAxisPt, data_xAxisPt, stamp, exp_en, exp_y, exp_x, exp_stamp);
            end
            if (c == 2) begin
                n_checks++;
                if ({en, data_xAxisPt, stamp} !== {1'b1, 64'd9, 64'd2}) begin
                    n_fail++;
                    $display("FAIL overshoot_second: got en=%b x=%0d st=%0d, want en=1 x=9 st=2",
                             en, data_xAxisPt, stamp);
                end
            end
        end
    endtask

    task automatic test_partial_flush();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            drive(1, (c < 2) ? 1 : 0, (c == 1) ? 1 : 0, (c == 5 || c == 8));
            n_checks++;
            if ({en, data_yAxisPt, data_xAxisPt, stamp} !== {exp_en, exp_y, exp_x, exp_stamp}) begin
                n_fail++;
                $display("FAIL partial c%0d: got en=%b y=%0d x=%0d st=%0d, want en=%b y=%0d x=%0d st=%0d",
                         c, en, data_yAxisPt, data_xAxisPt, stamp, exp_en, exp_y, exp_x, exp_stamp);
            end
            if (c == 5) begin
                n_checks++;
                if ({en, data_yAxisPt, data_xAxisPt, stamp} !== {1'b1, 64'd1, 64'd2, 64'd5}) begin
                    n_fail++;
                    $display("FAIL partial_emit: got en=%b y=%0d x=%0d st=%0d, want en=1 y=1 x=2 st=5",
                             en, data_yAxisPt, data_xAxisPt, stamp);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            drive(1, (c < 3) ? 1 : ((c == 3) ? 3 : 0), 0, (c == 3));
            n_checks++;
            if ({en, data_yAxisPt, data_xAxisPt, stamp} !== {exp_en, exp_y, exp_x, exp_stamp}) begin
                n_fail++;
                $display("FAIL b2b c%0d: got en=%b y=%0d x=%0d st=%0d, want en=%b y=%0d x=%0d st=%0d",
                         c, en, data_yAxisPt, data_xAxisPt, stamp, exp_en, exp_y, exp_x, exp_stamp);
            end
            if (c == 4) begin
                n_checks++;
                if ({en, data_yAxisPt, data_xAxisPt, stamp} !== {1'b1, 64'd0, 64'd6, 64'd4}) begin
                    n_fail++;
                    $display("FAIL b2b_second: got en=%b y=%0d x=%0d st=%0d, want en=1 y=0 x=6 st=4",
                             en, data_yAxisPt, data_xAxisPt, stamp);
                end
            end
        end
    endtask

    task automatic test_enable_off();
        logic [63:0]     snap_y, snap_x, snap_st;
        longint unsigned base;
        snap_y = exp_y; snap_x = exp_x; snap_st = exp_stamp;
        base = m_stamp;
        for (int c = 0; c < 10; c++) begin
            drive(0, 3, 3, 0);
            n_checks++;
            if ({en, data_yAxisPt, data_xAxisPt, stamp} !== {1'b0, snap_y, snap_x, snap_st}) begin
                n_fail++;
                $display("FAIL enable_off c%0d: got en=%b y=%0d x=%0d st=%0d, want en=0 y=%0d x=%0d st=%0d",
                         c, en, data_yAxisPt, data_xAxisPt, stamp, snap_y, snap_x, snap_st);
            end
        end
        for (int c = 10; c < 14; c++) begin
            drive(c != 10, (c == 11) ? 3 : ((c == 12) ? 1 : 0), (c == 11) ? 1 : 0, (c == 10));
            n_checks++;
            if ({en, data_yAxisPt, data_xAxisPt, stamp} !== {exp_en, exp_y, exp_x, exp_stamp}) begin
                n_fail++;
                $display("FAIL enable_resume c%0d: got en=%b y=%0d x=%0d st=%0d, want en=%b y=%0d x=%0d st=%0d",
                         c, en, data_yAxisPt, data_xAxisPt, stamp, exp_en, exp_y, exp_x, exp_stamp);
            end
            if (c == 12) begin
                n_checks++;
                if ({en, data_yAxisPt, stamp} !== {1'b1, 64'd1, 64'(base + 12)}) begin
                    n_fail++;
                    $display("FAIL enable_stamp: got en=%b y=%0d st=%0d, want en=1 y=1 st=%0d",
                             en, data_yAxisPt, stamp, base + 12);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive(1, 1, 1, 0);
        end
        drive(1, 1, 0, 0);
        drive(1, 1, 0, 0);
        #2;
        reset = 0;
        model_reset();
        #1;
        n_checks++;
        if ({en, data_yAxisPt, data_xAxisPt, stamp} !== {1'b0, 64'd0, 64'd0, 64'd0}) begin
            n_fail++;
            $display("FAIL async_reset: got en=%b y=%0d x=%0d st=%0d, want all zero",
                     en, data_yAxisPt, data_xAxisPt, stamp);
        end
        @(negedge clock);
        reset = 1;
        for (int c = 0; c < 5; c++) begin
            drive(1, (c < 4) ? 1 : 0, 0, 0);
            n_checks++;
            if ({en, data_yAxisPt, data_xAxisPt, stamp} !== {exp_en, exp_y, exp_x, exp_stamp}) begin
                n_fail++;
                $display("FAIL post_reset c%0d: got en=%b y=%0d x=%0d st=%0d, want en=%b y=%0d x=%0d st=%0d",
                         c, en, data_yAxisPt, data_xAxisPt, stamp, exp_en, exp_y, exp_x, exp_stamp);
            end
            if (c == 3) begin
                n_checks++;
                if ({en, data_xAxisPt, stamp} !== {1'b1, 64'd4, 64'd3}) begin
                    n_fail++;
                    $display("FAIL post_reset_close: got en=%b x=%0d st=%0d, want en=1 x=4 st=3",
                             en, data_xAxisPt, stamp);
                end
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 500; c++) begin
            drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  $urandom_range(0, 5) == 0);
            n_checks++;
            if ({en, data_yAxisPt, data_xAxisPt, stamp} !== {exp_en, exp_y, exp_x, exp_stamp}) begin
                n_fail++;
                $display("FAIL random c%0d: got en=%b y=%0d x=%0d st=%0d, want en=%b y=%0d x=%0d st=%0d",
                         c, en, data_yAxisPt, data_xAxisPt, stamp, exp_en, exp_y, exp_x, exp_stamp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_window();
        test_overshoot();
        test_partial_flush();
        test_back_to_back();
        test_enable_off();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
